// File: rtl/sm_cache_block.sv
// Cache-side coherence controller for a single block: turns CPU requests into
// directory messages and services fetch/invalidate/reply traffic from the directory.
module sm_cache_block #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpuRead,
  input  logic              cpuWrite,
  input  logic [TAG_W-1:0]  cpuAddr,
  input  logic [DATA_W-1:0] cpuWriteData,
  output logic              cpuDone,
  output logic [DATA_W-1:0] cpuReadData,
  input  logic              fetch,
  input  logic              invalidateIn,
  input  logic              dataValueReply,
  input  logic [DATA_W-1:0] replyData,
  output logic              readMiss,
  output logic              writeMiss,
  output logic              writeBack,
  output logic [TAG_W-1:0]  msgAddr,
  output logic [DATA_W-1:0] msgData,
  output logic [2:0]        currentState
);

  typedef enum logic [2:0] {
    ST_I       = 3'b000,
    ST_S       = 3'b001,
    ST_M       = 3'b010,
    ST_IS_WAIT = 3'b011,
    ST_IM_WAIT = 3'b100,
    ST_EVICT   = 3'b101
  } state_t;

  state_t              state_q;
  logic [TAG_W-1:0]    tag_q;
  logic [DATA_W-1:0]   data_q;
  logic                anyReq;
  logic                tagMatch;

  assign anyReq       = cpuRead | cpuWrite;
  assign tagMatch     = (tag_q == cpuAddr);
  assign currentState = state_q;

  // A simultaneous read and write is handled as a write everywhere below.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_I;
      tag_q       <= '0;
      data_q      <= '0;
      cpuDone     <= 1'b0;
      cpuReadData <= '0;
      readMiss    <= 1'b0;
      writeMiss   <= 1'b0;
      writeBack   <= 1'b0;
      msgAddr     <= '0;
      msgData     <= '0;
    end else begin
      cpuDone   <= 1'b0;
      readMiss  <= 1'b0;
      writeMiss <= 1'b0;
      writeBack <= 1'b0;
      case (state_q)
        ST_I: begin
          if (anyReq) begin
            readMiss  <= ~cpuWrite;
            writeMiss <= cpuWrite;
            msgAddr   <= cpuAddr;
            tag_q     <= cpuAddr;
            state_q   <= cpuWrite ? ST_IM_WAIT : ST_IS_WAIT;
          end
        end
        ST_S: begin
          if (invalidateIn) begin
            state_q <= ST_I;
          end else if (anyReq && tagMatch) begin
            if (cpuWrite) begin
              writeMiss <= 1'b1;
              msgAddr   <= cpuAddr;
              state_q   <= ST_IM_WAIT;
            end else begin
              cpuDone     <= 1'b1;
              cpuReadData <= data_q;
            end
          end else if (anyReq) begin
            readMiss  <= ~cpuWrite;
            writeMiss <= cpuWrite;
            msgAddr   <= cpuAddr;
            tag_q     <= cpuAddr;
            state_q   <= cpuWrite ? ST_IM_WAIT : ST_IS_WAIT;
          end
        end
        ST_M: begin
          if (invalidateIn || fetch) begin
            writeBack <= 1'b1;
            msgAddr   <= tag_q;
            msgData   <= data_q;
            state_q   <= invalidateIn ? ST_I : ST_S;
          end else if (anyReq && tagMatch) begin
            cpuDone <= 1'b1;
            if (cpuWrite) begin
              data_q <= cpuWriteData;
            end else begin
              cpuReadData <= data_q;
            end
          end else if (anyReq) begin
            writeBack <= 1'b1;
            msgAddr   <= tag_q;
            msgData   <= data_q;
            state_q   <= ST_EVICT;
          end
        end
        ST_EVICT: begin
          // The victim is already written back, so a vanished request leaves the block invalid.
          if (anyReq) begin
            readMiss  <= ~cpuWrite;
            writeMiss <= cpuWrite;
            msgAddr   <= cpuAddr;
            tag_q     <= cpuAddr;
            state_q   <= cpuWrite ? ST_IM_WAIT : ST_IS_WAIT;
          end else begin
            state_q <= ST_I;
          end
        end
        ST_IS_WAIT: begin
          if (dataValueReply) begin
            data_q      <= replyData;
            cpuReadData <= replyData;
            cpuDone     <= 1'b1;
            state_q     <= ST_S;
          end
        end
        ST_IM_WAIT: begin
          if (dataValueReply) begin
            data_q  <= cpuWriteData;
            cpuDone <= 1'b1;
            state_q <= ST_M;
          end
        end
        default: state_q <= ST_I;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_cache_block.sv
// Bench for sm_cache_block: directed vector table, reset corner cases and a
// protocol-respecting random run checked against a flag-based reference model.
module tb_sm_cache_block;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       fe;
    logic       inv;
    logic       dvr;
    logic [7:0] rdat;
    logic [2:0] st;
    logic       done;
    logic       rm;
    logic       wm;
    logic       wb;
    logic [3:0] mAddr;
    logic [7:0] mData;
    logic [7:0] rData;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpuRead, cpuWrite, fetch, invalidateIn, dataValueReply;
  logic [3:0] cpuAddr;
  logic [7:0] cpuWriteData, replyData;
  logic       cpuDone, readMiss, writeMiss, writeBack;
  logic [7:0] cpuReadData, msgData;
  logic [3:0] msgAddr;
  logic [2:0] currentState;

  int vectors = 0;
  int miscompares = 0;

  sm_cache_block #(.TAG_W(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuAddr(cpuAddr), .cpuWriteData(cpuWriteData),
    .cpuDone(cpuDone), .cpuReadData(cpuReadData),
    .fetch(fetch), .invalidateIn(invalidateIn), .dataValueReply(dataValueReply), .replyData(replyData),
    .readMiss(readMiss), .writeMiss(writeMiss), .writeBack(writeBack),
    .msgAddr(msgAddr), .msgData(msgData), .currentState(currentState)
  );

  always #5 clock = ~clock;

  // Reference model: the block is described by valid/dirty flags plus what it is waiting for
  // (0 nothing, 1 read fill, 2 write fill, 3 victim just written back).
  bit       mValid, mDirty;
  int       mPend;
  bit [3:0] mTag, mAddrOut;
  bit [7:0] mData, mDataOut, mRData;
  bit       mDone, mRm, mWm, mWb;

  task automatic modelReset();
    mValid = 0; mDirty = 0; mPend = 0; mTag = 0; mAddrOut = 0;
    mData = 0; mDataOut = 0; mRData = 0;
    mDone = 0; mRm = 0; mWm = 0; mWb = 0;
  endtask

  task automatic issueMiss(input bit [3:0] a, input bit w);
    mTag = a; mAddrOut = a; mValid = 0; mDirty = 0;
    mPend = w ? 2 : 1;
    if (w) mWm = 1; else mRm = 1;
  endtask

  task automatic writeBackNow();
    mWb = 1; mAddrOut = mTag; mDataOut = mData;
  endtask

  task automatic modelStep(input vec_t v);
    bit anyReq, wantW, hit;
    anyReq = v.rd | v.wr;
    wantW  = v.wr;
    hit    = mValid && (mPend == 0) && (mTag == v.addr);
    mDone = 0; mRm = 0; mWm = 0; mWb = 0;
    if (mPend == 3) begin
      mValid = 0; mDirty = 0;
      if (anyReq) issueMiss(v.addr, wantW); else mPend = 0;
    end else if (mPend != 0) begin
      if (v.dvr) begin
        mDone = 1; mValid = 1;
        if (mPend == 1) begin mData = v.rdat; mRData = v.rdat; mDirty = 0; end
        else begin mData = v.wd; mDirty = 1; end
        mPend = 0;
      end
    end else if (mValid && mDirty) begin
      if (v.inv || v.fe) begin
        writeBackNow();
        if (v.inv) mValid = 0; else mDirty = 0;
      end else if (anyReq) begin
        if (hit) begin
          mDone = 1;
          if (wantW) mData = v.wd; else mRData = mData;
        end else begin
          writeBackNow();
          mPend = 3;
        end
      end
    end else if (mValid) begin
      if (v.inv) mValid = 0;
      else if (anyReq) begin
        if (hit && !wantW) begin mDone = 1; mRData = mData; end
        else if (hit) begin mWm = 1; mAddrOut = v.addr; mPend = 2; mValid = 0; end
        else issueMiss(v.addr, wantW);
      end
    end else if (anyReq) begin
      issueMiss(v.addr, wantW);
    end
  endtask

  function automatic vec_t modelExpect();
    vec_t e;
    e = '{default: '0};
    if (mPend == 3) e.st = 3'd5;
    else if (mPend == 1) e.st = 3'd3;
    else if (mPend == 2) e.st = 3'd4;
    else if (mValid && mDirty) e.st = 3'd2;
    else if (mValid) e.st = 3'd1;
    else e.st = 3'd0;
    e.done = mDone; e.rm = mRm; e.wm = mWm; e.wb = mWb;
    e.mAddr = mAddrOut; e.mData = mDataOut; e.rData = mRData;
    return e;
  endfunction

  function automatic vec_t mk(input logic rd, wr, input logic [3:0] addr, input logic [7:0] wd,
                              input logic fe, inv, dvr, input logic [7:0] rdat,
                              input logic [2:0] st, input logic done, rm, wm, wb,
                              input logic [3:0] mAddr, input logic [7:0] mData, rData);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.fe = fe; v.inv = inv; v.dvr = dvr; v.rdat = rdat;
    v.st = st; v.done = done; v.rm = rm; v.wm = wm; v.wb = wb;
    v.mAddr = mAddr; v.mData = mData; v.rData = rData;
    return v;
  endfunction

  task automatic driveInputs(input vec_t v);
    cpuRead = v.rd; cpuWrite = v.wr; cpuAddr = v.addr; cpuWriteData = v.wd;
    fetch = v.fe; invalidateIn = v.inv; dataValueReply = v.dvr; replyData = v.rdat;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    driveInputs(v);
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t e);
    vectors++;
    if (currentState !== e.st || cpuDone !== e.done || readMiss !== e.rm || writeMiss !== e.wm ||
        writeBack !== e.wb || msgAddr !== e.mAddr || msgData !== e.mData || cpuReadData !== e.rData) begin
      miscompares++;
      $display("[TB] FAIL %s: got st=%0d done=%0b rm=%0b wm=%0b wb=%0b addr=%h data=%h rdata=%h, expected st=%0d done=%0b rm=%0b wm=%0b wb=%0b addr=%h data=%h rdata=%h",
               name, currentState, cpuDone, readMiss, writeMiss, writeBack, msgAddr, msgData, cpuReadData,
               e.st, e.done, e.rm, e.wm, e.wb, e.mAddr, e.mData, e.rData);
    end
  endtask

  vec_t vecs[$];
  vec_t idle;
  vec_t zeroOut;

  initial begin
    vec_t v;
    vec_t e;
    bit   reqActive;
    bit   reqRd, reqWr;
    bit [3:0] reqAddr;
    bit [7:0] reqWd;
    int   kind;

    idle    = mk(0,0,4'h0,8'h00,0,0,0,8'h00, 3'd0,0,0,0,0,4'h0,8'h00,8'h00);
    zeroOut = idle;
    driveInputs(idle);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetState", zeroOut);
    @(negedge clock);
    reset = 1'b0;

    // Reset in the middle of a read miss, then a stray reply must be ignored.
    applyStimulus(mk(1,0,4'h5,8'h00,0,0,0,8'h00, 3'd3,0,1,0,0,4'h5,8'h00,8'h00));
    checkOutput("missBeforeReset", mk(1,0,4'h5,8'h00,0,0,0,8'h00, 3'd3,0,1,0,0,4'h5,8'h00,8'h00));
    @(negedge clock);
    driveInputs(idle);
    reset = 1'b1;
    #1;
    checkOutput("resetMidWait", zeroOut);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(mk(0,0,4'h0,8'h00,0,0,1,8'h77, 3'd0,0,0,0,0,4'h0,8'h00,8'h00));
    checkOutput("replyAfterReset", zeroOut);
    applyStimulus(idle);
    checkOutput("idleAfterReset", zeroOut);

    //             rd wr addr  wd    fe inv dvr rdat   st   dn rm wm wb mAddr mData  rData
    vecs.push_back(mk(1,0,4'h3,8'h00,0,0,0,8'h00, 3'd3,0,1,0,0,4'h3,8'h00,8'h00));
    vecs.push_back(mk(1,0,4'h3,8'h00,0,0,1,8'hA5, 3'd1,1,0,0,0,4'h3,8'h00,8'hA5));
    vecs.push_back(mk(0,0,4'h3,8'h00,0,0,0,8'h00, 3'd1,0,0,0,0,4'h3,8'h00,8'hA5));
    vecs.push_back(mk(1,0,4'h3,8'h00,0,0,0,8'h00, 3'd1,1,0,0,0,4'h3,8'h00,8'hA5));
    vecs.push_back(mk(0,1,4'h3,8'h5C,0,0,0,8'h00, 3'd4,0,0,1,0,4'h3,8'h00,8'hA5));
    vecs.push_back(mk(0,1,4'h3,8'h5C,0,0,1,8'hA5, 3'd2,1,0,0,0,4'h3,8'h00,8'hA5));
    vecs.push_back(mk(0,0,4'h3,8'h00,1,0,0,8'h00, 3'd1,0,0,0,1,4'h3,8'h5C,8'hA5));
    vecs.push_back(mk(0,1,4'h3,8'h5C,0,0,0,8'h00, 3'd4,0,0,1,0,4'h3,8'h5C,8'hA5));
    vecs.push_back(mk(0,1,4'h3,8'h5C,0,0,1,8'h00, 3'd2,1,0,0,0,4'h3,8'h5C,8'hA5));
    vecs.push_back(mk(0,0,4'h3,8'h00,0,0,0,8'h00, 3'd2,0,0,0,0,4'h3,8'h5C,8'hA5));
    vecs.push_back(mk(1,0,4'h7,8'h00,0,0,0,8'h00, 3'd5,0,0,0,1,4'h3,8'h5C,8'hA5));
    vecs.push_back(mk(1,0,4'h7,8'h00,0,0,0,8'h00, 3'd3,0,1,0,0,4'h7,8'h5C,8'hA5));
    vecs.push_back(mk(1,0,4'h7,8'h00,0,0,1,8'h11, 3'd1,1,0,0,0,4'h7,8'h5C,8'h11));
    vecs.push_back(mk(1,0,4'h7,8'h00,0,0,0,8'h00, 3'd1,1,0,0,0,4'h7,8'h5C,8'h11));
    vecs.push_back(mk(0,0,4'h0,8'h00,0,0,0,8'h00, 3'd1,0,0,0,0,4'h7,8'h5C,8'h11));
    vecs.push_back(mk(0,1,4'h7,8'h3C,0,0,0,8'h00, 3'd4,0,0,1,0,4'h7,8'h5C,8'h11));
    vecs.push_back(mk(0,1,4'h7,8'h3C,0,0,1,8'h99, 3'd2,1,0,0,0,4'h7,8'h5C,8'h11));
    vecs.push_back(mk(0,0,4'h0,8'h00,0,0,0,8'h00, 3'd2,0,0,0,0,4'h7,8'h5C,8'h11));
    vecs.push_back(mk(0,1,4'h7,8'h81,0,0,0,8'h00, 3'd2,1,0,0,0,4'h7,8'h5C,8'h11));
    vecs.push_back(mk(0,0,4'h0,8'h00,0,0,0,8'h00, 3'd2,0,0,0,0,4'h7,8'h5C,8'h11));
    vecs.push_back(mk(1,0,4'h7,8'h00,1,1,0,8'h00, 3'd0,0,0,0,1,4'h7,8'h81,8'h11));
    vecs.push_back(mk(1,0,4'h7,8'h00,0,0,0,8'h00, 3'd3,0,1,0,0,4'h7,8'h81,8'h11));
    vecs.push_back(mk(1,0,4'h7,8'h00,0,0,1,8'h42, 3'd1,1,0,0,0,4'h7,8'h81,8'h42));
    vecs.push_back(mk(0,0,4'h0,8'h00,0,0,0,8'h00, 3'd1,0,0,0,0,4'h7,8'h81,8'h42));
    vecs.push_back(mk(0,0,4'h0,8'h00,0,1,0,8'h00, 3'd0,0,0,0,0,4'h7,8'h81,8'h42));
    vecs.push_back(mk(0,0,4'h0,8'h00,1,0,0,8'h00, 3'd0,0,0,0,0,4'h7,8'h81,8'h42));
    vecs.push_back(mk(1,1,4'h2,8'h6E,0,0,0,8'h00, 3'd4,0,0,1,0,4'h2,8'h81,8'h42));
    vecs.push_back(mk(1,1,4'h2,8'h6E,0,0,1,8'hF0, 3'd2,1,0,0,0,4'h2,8'h81,8'h42));
    vecs.push_back(mk(0,0,4'h0,8'h00,0,0,0,8'h00, 3'd2,0,0,0,0,4'h2,8'h81,8'h42));
    vecs.push_back(mk(1,0,4'h2,8'h00,0,0,0,8'h00, 3'd2,1,0,0,0,4'h2,8'h81,8'h6E));
    vecs.push_back(mk(0,0,4'h0,8'h00,0,0,0,8'h00, 3'd2,0,0,0,0,4'h2,8'h81,8'h6E));
    vecs.push_back(mk(0,0,4'h0,8'h00,1,0,0,8'h00, 3'd1,0,0,0,1,4'h2,8'h6E,8'h6E));
    vecs.push_back(mk(1,0,4'h9,8'h00,0,0,0,8'h00, 3'd3,0,1,0,0,4'h9,8'h6E,8'h6E));
    vecs.push_back(mk(1,0,4'h9,8'h00,0,0,1,8'h0D, 3'd1,1,0,0,0,4'h9,8'h6E,8'h0D));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("table%0d", i), vecs[i]);
    end

    // Random traffic: the CPU holds each request until the model predicts its completion.
    @(negedge clock);
    driveInputs(idle);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    reqActive = 0; reqRd = 0; reqWr = 0; reqAddr = 0; reqWd = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!reqActive && $urandom_range(0, 1) == 1) begin
        reqActive = 1;
        kind      = $urandom_range(0, 4);
        reqRd     = (kind <= 1) || (kind == 4);
        reqWr     = (kind >= 2);
        reqAddr   = 4'($urandom_range(0, 3));
        reqWd     = 8'($urandom);
      end
      v       = idle;
      v.rd    = reqActive & reqRd;
      v.wr    = reqActive & reqWr;
      v.addr  = reqAddr;
      v.wd    = reqWd;
      v.fe    = ($urandom_range(0, 7) == 0);
      v.inv   = ($urandom_range(0, 9) == 0);
      v.dvr   = ($urandom_range(0, 3) == 0);
      v.rdat  = 8'($urandom);
      applyStimulus(v);
      modelStep(v);
      e = modelExpect();
      checkOutput("random", e);
      if (mDone) reqActive = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
